memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 48, data word width.
- ACCESS_CYCLES, 8, memory access hold time in cycles; legal range 1..1023.

REQ-002 Ports SHALL be:
- clock  in  1  single clock; all state changes on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_a  in  1  level request from block-data requester.
- we_a  in  1  A write (1) / read (0).
- wdata_a  in  WIDTH  A write data.
- req_b  in  1  level request from hash requester.
- we_b  in  1  B write / read.
- wdata_b  in  WIDTH  B write data; hash occupies bits [7:0].
- mem_rdata  in  WIDTH  memory read data.
- mem_we  out  1  memory write enable.
- mem_access_type  out  1  0 = block-data region, 1 = hash region.
- mem_wdata  out  WIDTH  memory write data.
- gnt_a, gnt_b  out  1 each  grant, ACCESS through RELEASE.
- done_a, done_b  out  1 each  one-cycle completion pulse.
- rdata  out  WIDTH  captured read data.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, DONE, RELEASE.
REQ-004 IDLE, one request high: that requester wins; next cycle enter ACCESS.
REQ-005 IDLE, both requests high in the same cycle: winner SHALL be the requester not served last (round-robin).
REQ-006 On leaving IDLE the block SHALL latch winner id, we_x and wdata_x; later changes on those inputs SHALL be ignored until IDLE is re-entered.
REQ-007 In ACCESS, mem_we SHALL equal the latched we; mem_wdata SHALL equal the latched wdata; mem_access_type SHALL equal the winner id (A = 0, B = 1).
REQ-008 ACCESS SHALL last exactly ACCESS_CYCLES cycles, timed by a counter cleared on ACCESS entry.
REQ-009 On the last ACCESS cycle, for a read, rdata SHALL capture mem_rdata; for a write, rdata SHALL hold its previous value.
REQ-010 DONE SHALL last one cycle and pulse the winner's done_x.
REQ-011 In DONE and RELEASE, mem_we SHALL be 0 and mem_access_type SHALL keep the winner id.
REQ-012 RELEASE SHALL persist while the winner's req_x is high; when it is low, return to IDLE.
REQ-013 Latency: req sampled high in IDLE at edge t -> gnt_x and mem_we valid from t+1 to t+ACCESS_CYCLES; done_x at t+ACCESS_CYCLES+1.
REQ-014 A winner dropping req during ACCESS SHALL NOT abort the access; the FSM then passes through RELEASE in one cycle.
REQ-015 A loser's request SHALL remain pending, unserviced, until IDLE.
REQ-016 With both requests held continuously, service SHALL alternate A, B, A, B.
REQ-017 In IDLE: mem_we = 0, mem_wdata = 0, mem_access_type = 0, all gnt and done = 0.
REQ-018 gnt_a and gnt_b SHALL never be high together; done_x SHALL never assert without gnt_x.

Reset
REQ-019 resetn low SHALL asynchronously force: state IDLE, counter 0, rdata 0, all outputs 0, last-served = B (so A wins the first tie).
REQ-020 Reset mid-ACCESS SHALL drop mem_we immediately, with no done pulse.

Structure
REQ-021 A shared package SHALL hold the state enumeration, requester id constants (A = 0, B = 1), and WIDTH and ACCESS_CYCLES defaults.
REQ-022 One sub-module, access_timer, SHALL implement the clear/enable cycle counter with a terminal-count flag.

Verification
REQ-023 A only: req_a = 1, we_a = 1, wdata_a = 48'h0000_1234_5678 -> mem_we high 8 cycles with that data, type 0, done_a at t+9.
REQ-024 B read: mem_rdata = 48'h0000_0000_00AB on the last access cycle -> rdata = 48'h0000_0000_00AB, type 1, done_b pulse.
REQ-025 Simultaneous req_a and req_b after reset, both held -> grant order A, B, A; gnt signals never overlap.
REQ-026 req_a dropped on the 3rd ACCESS cycle -> access completes full 8 cycles, done_a pulses, IDLE two cycles later.
REQ-027 resetn low on the 4th ACCESS cycle -> mem_we = 0 in the same cycle, no done, IDLE; next tie goes to A.
REQ-028 ACCESS_CYCLES = 1 -> done at t+2; no lost or duplicated cycles.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared states, requester ids and defaults for the memory arbiter
package memory_arbiter_pkg;
  localparam int WIDTH_DEF = 48;
  localparam int ACCESS_CYCLES_DEF = 8;
  localparam int CNT_W = 10;
  localparam logic ID_A = 1'b0;
  localparam logic ID_B = 1'b1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RELEASE} state_t;
endpackage

// File: rtl/memory_arbiter_access_timer.sv
// access_timer: clear/enable cycle counter flagging the last counted cycle
module access_timer
  import memory_arbiter_pkg::*;
#(
  parameter int LAST = ACCESS_CYCLES_DEF - 1
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic en,
  output logic tc
);
  logic [CNT_W-1:0] count;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + 1'b1;
  assign tc = en && (count == CNT_W'(LAST));
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin two-requester arbiter holding each memory access for ACCESS_CYCLES
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_a,
  input  logic             we_a,
  input  logic [WIDTH-1:0] wdata_a,
  input  logic             req_b,
  input  logic             we_b,
  input  logic [WIDTH-1:0] wdata_b,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             mem_we,
  output logic             mem_access_type,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             done_a,
  output logic             done_b,
  output logic [WIDTH-1:0] rdata,
  output logic             busy
);
  state_t state, next_state;
  logic winner, last_served, we_l, pick, tc, active, start;
  logic [WIDTH-1:0] wdata_l;
  access_timer #(.LAST(ACCESS_CYCLES - 1)) u_timer (
    .clock (clock),
    .resetn(resetn),
    .clear (state != ACCESS),
    .en    (state == ACCESS),
    .tc    (tc)
  );
  always_comb begin
    start = (state == IDLE) && (req_a || req_b);
    pick = (req_a && req_b) ? ~last_served : (req_a ? ID_A : ID_B);
    next_state = state;
    case (state)
      IDLE:    next_state = start ? ACCESS : IDLE;
      ACCESS:  next_state = tc ? DONE : ACCESS;
      DONE:    next_state = RELEASE;
      RELEASE: next_state = (winner ? req_b : req_a) ? RELEASE : IDLE;
      default: next_state = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      winner <= ID_A;
      last_served <= ID_B;
      we_l <= 1'b0;
      wdata_l <= '0;
      rdata <= '0;
    end else begin
      state <= next_state;
      if (start) begin
        winner <= pick;
        last_served <= pick;
        we_l <= pick ? we_b : we_a;
        wdata_l <= pick ? wdata_b : wdata_a;
      end
      if (state == ACCESS && tc && !we_l) rdata <= mem_rdata;
    end
  // outputs decode from state and latched request only, so they fall with the async reset
  always_comb begin
    active = state != IDLE;
    busy = active;
    mem_we = (state == ACCESS) && we_l;
    mem_wdata = active ? wdata_l : '0;
    mem_access_type = active && winner;
    gnt_a = active && !winner;
    gnt_b = active && winner;
    done_a = (state == DONE) && !winner;
    done_b = (state == DONE) && winner;
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scoreboard bench for memory_arbiter
module tb_memory_arbiter;
  typedef struct {
    logic        id;
    logic [47:0] rd;
  } exp_t;
  logic clock = 1'b0;
  logic resetn;
  logic req_a, we_a, req_b, we_b;
  logic [47:0] wdata_a, wdata_b, mem_rdata;
  logic mem_we, mem_access_type, gnt_a, gnt_b, done_a, done_b, busy;
  logic [47:0] mem_wdata, rdata;
  logic req_a1, we_a1, zero;
  logic [47:0] wdata_a1, mem_rdata1, zero_w;
  logic mem_we1, mem_access_type1, gnt_a1, gnt_b1, done_a1, done_b1, busy1;
  logic [47:0] mem_wdata1, rdata1;
  int checks = 0;
  int failures = 0;
  exp_t sb[$];
  exp_t e;
  always #5 clock = ~clock;
  memory_arbiter dut (
    .clock(clock), .resetn(resetn), .req_a(req_a), .we_a(we_a), .wdata_a(wdata_a),
    .req_b(req_b), .we_b(we_b), .wdata_b(wdata_b), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_access_type(mem_access_type), .mem_wdata(mem_wdata),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .done_a(done_a), .done_b(done_b), .rdata(rdata), .busy(busy)
  );
  memory_arbiter #(.ACCESS_CYCLES(1)) dut1 (
    .clock(clock), .resetn(resetn), .req_a(req_a1), .we_a(we_a1), .wdata_a(wdata_a1),
    .req_b(zero), .we_b(zero), .wdata_b(zero_w), .mem_rdata(mem_rdata1),
    .mem_we(mem_we1), .mem_access_type(mem_access_type1), .mem_wdata(mem_wdata1),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1), .done_a(done_a1), .done_b(done_b1), .rdata(rdata1), .busy(busy1)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push_exp(input logic id, input logic [47:0] rd);
    exp_t t;
    t.id = id;
    t.rd = rd;
    sb.push_back(t);
  endtask
  // scoreboard side: every done pulse must match the oldest outstanding request
  always @(negedge clock) if (resetn) begin
    chk("gnt_overlap", gnt_a & gnt_b, 0);
    chk("done_without_gnt", (done_a & ~gnt_a) | (done_b & ~gnt_b), 0);
    if (done_a | done_b) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_id", done_b, e.id);
        chk("done_rdata", rdata, e.rd);
      end
    end
  end
  task automatic single(input logic id, input logic we, input logic [47:0] wd,
                        input logic [47:0] rd, input int drop_at, input logic [47:0] rd_exp);
    if (id) begin req_b = 1; we_b = we; wdata_b = wd; end
    else begin req_a = 1; we_a = we; wdata_a = wd; end
    push_exp(id, rd_exp);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clock);
      mem_rdata = (k == 8) ? rd : 48'hDEAD_BEEF_0000;
      if (k == 2) begin we_a = ~we; we_b = ~we; wdata_a = ~wd; wdata_b = ~wd; end
      if (k == drop_at || k == 9) begin if (id) req_b = 0; else req_a = 0; end
      if (k <= 8) begin
        chk("access_we", mem_we, we);
        chk("access_wdata", mem_wdata, wd);
        chk("access_type", mem_access_type, id);
        chk("access_gnt", id ? gnt_b : gnt_a, 1);
        chk("access_no_done", done_a | done_b, 0);
      end else if (k == 9) begin
        chk("done_pulse", id ? done_b : done_a, 1);
        chk("done_we", mem_we, 0);
        chk("done_type", mem_access_type, id);
      end else if (k == 10) chk("release_busy", busy, 1);
      else begin
        chk("idle_busy", busy, 0);
        chk("rdata_hold", rdata, rd_exp);
      end
    end
    mem_rdata = '0;
  endtask
  initial begin
    logic ok;
    logic nid;
    resetn = 0; req_a = 0; we_a = 0; wdata_a = '0; req_b = 0; we_b = 0; wdata_b = '0; mem_rdata = '0;
    req_a1 = 0; we_a1 = 0; wdata_a1 = '0; mem_rdata1 = '0; zero = 0; zero_w = '0;
    repeat (2) @(negedge clock);
    chk("reset_busy", busy, 0);
    chk("reset_rdata", rdata, 0);
    chk("reset_we", mem_we, 0);
    chk("reset_gnt", {gnt_a, gnt_b, done_a, done_b}, 0);
    chk("reset_type_wdata", {mem_access_type, mem_wdata}, 0);
    resetn = 1;
    @(negedge clock);
    // single-cycle access instance: write then read, done one cycle after the access
    for (int j = 0; j < 2; j++) begin
      req_a1 = 1; we_a1 = (j == 0); wdata_a1 = 48'h0000_0000_0ABC;
      @(negedge clock);
      mem_rdata1 = 48'h0000_5A5A_5A5A;
      chk("ac1_we", mem_we1, j == 0);
      chk("ac1_wdata", mem_wdata1, 48'h0000_0000_0ABC);
      chk("ac1_gnt", gnt_a1, 1);
      chk("ac1_no_done", done_a1, 0);
      @(negedge clock);
      mem_rdata1 = '0;
      req_a1 = 0;
      chk("ac1_done", done_a1, 1);
      chk("ac1_done_we", mem_we1, 0);
      chk("ac1_rdata", rdata1, (j == 0) ? 48'h0 : 48'h0000_5A5A_5A5A);
      @(negedge clock);
      chk("ac1_single_done", done_a1, 0);
      chk("ac1_release", busy1, 1);
      @(negedge clock);
      chk("ac1_idle", busy1, 0);
    end
    single(0, 1, 48'h0000_1234_5678, 48'h0, 99, 48'h0);
    single(1, 0, 48'h0000_0000_0077, 48'h0000_0000_00AB, 99, 48'h0000_0000_00AB);
    single(0, 1, 48'h0000_CAFE_F00D, 48'h0, 3, 48'h0000_0000_00AB);
    // tie straight after reset, both held: A, B, A
    resetn = 0;
    @(negedge clock);
    resetn = 1;
    req_a = 1; req_b = 1; we_a = 1; we_b = 1; wdata_a = 48'h0000_0000_AAAA; wdata_b = 48'h0000_0000_BBBB;
    push_exp(0, 48'h0); push_exp(1, 48'h0); push_exp(0, 48'h0);
    for (int i = 0; i < 3; i++) begin
      nid = (i == 1);
      ok = 0;
      for (int w = 0; w < 40 && !ok; w++) begin
        @(negedge clock);
        if (done_a | done_b) ok = 1;
      end
      chk("tie_timeout", ok, 1);
      chk("tie_order", done_b, nid);
      if (nid) req_b = 0; else req_a = 0;
      if (i == 2) req_b = 0;
      @(negedge clock);
      @(negedge clock);
      chk("tie_idle", busy, 0);
      if (i < 2) begin if (nid) req_b = 1; else req_a = 1; end
    end
    // reset mid-access after A served last: no done, and the next tie still goes to A
    req_a = 1; we_a = 1; wdata_a = 48'h0000_0000_1111;
    repeat (4) @(negedge clock);
    chk("pre_reset_we", mem_we, 1);
    resetn = 0;
    #1;
    chk("reset_async_we", mem_we, 0);
    chk("reset_async_busy", busy, 0);
    chk("reset_async_gnt", gnt_a, 0);
    req_a = 0;
    @(negedge clock);
    chk("reset_no_done", done_a | done_b, 0);
    resetn = 1; req_a = 1; req_b = 1; we_a = 0; we_b = 0;
    push_exp(0, 48'h0);
    @(negedge clock);
    chk("post_reset_tie_a", gnt_a, 1);
    chk("post_reset_tie_b", gnt_b, 0);
    ok = 0;
    for (int w = 0; w < 40 && !ok; w++) begin
      @(negedge clock);
      if (done_a | done_b) ok = 1;
    end
    chk("post_reset_timeout", ok, 1);
    req_a = 0; req_b = 0;
    repeat (3) @(negedge clock);
    chk("final_idle", busy, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
